rx_latency_stamper: RTL and testbench

RX_LATENCY_STAMPER -- requirements
Module: rx_latency_stamper

---
 rtl/rx_timing_pkg.sv | 46 ++++
 rtl/sync_bit.sv | 21 ++
 rtl/rx_latency_stamper.sv | 141 ++++++++++++++
 tb/tb_rx_latency_stamper.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_timing_pkg.sv
// Shared FSM state type and parameter legality checks
// for the RX latency stamper.
package rx_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DONE
  } rx_state_e;

  function automatic bit width_ok(
    input int dw,
    input int kw
  );
    return (dw >= 64) && (dw % 8 == 0) &&
           (kw == dw / 8);
  endfunction

  function automatic bit stamp_ok(
    input int dw,
    input int cw,
    input int lsb
  );
    return (cw >= 8) && (cw <= 64) &&
           (lsb >= 0) && (lsb + cw <= dw);
  endfunction

  function automatic bit timeout_ok(
    input int          cw,
    input logic [63:0] to
  );
    logic [63:0] maxv;
    if (cw >= 64)
      maxv = 64'hFFFF_FFFF_FFFF_FFFE;
    else
      maxv = (64'd1 << cw) - 64'd2;
    return (to >= 64'd1) && (to <= maxv);
  endfunction

  function automatic bit sync_ok(
    input int ss
  );
    return (ss >= 2) && (ss <= 4);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser.
// Ports: clk, areset (async high), d (async in), q (sync out).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rx_latency_stamper.sv
// Stamps the first beat after a TX start with the elapsed cycle count.
// Ports: s_axis_* in, m_axis_* out, tx_started req/ack, latency result.
module rx_latency_stamper
  import rx_timing_pkg::*;
#(
  parameter int          AXIS_DATA_WIDTH = 512,
  parameter int          AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int          CNT_WIDTH       = 48,
  parameter int          STAMP_LSB       = 464,
  parameter logic [63:0] TIMEOUT_CYCLES  = 64'd1 << 20,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       tx_started_req,
  output logic                       tx_started_ack,
  output logic [CNT_WIDTH-1:0]       latency_out,
  output logic                       latency_valid,
  output logic                       timeout
);

  if (!width_ok(AXIS_DATA_WIDTH, AXIS_KEEP_WIDTH)) begin : g_bad_w
    $error("rx_latency_stamper: bad data/keep width");
  end
  if (!stamp_ok(AXIS_DATA_WIDTH, CNT_WIDTH, STAMP_LSB)) begin : g_bad_s
    $error("rx_latency_stamper: stamp field out of range");
  end
  if (!timeout_ok(CNT_WIDTH, TIMEOUT_CYCLES)) begin : g_bad_t
    $error("rx_latency_stamper: TIMEOUT_CYCLES out of range");
  end
  if (!sync_ok(SYNC_STAGES)) begin : g_bad_y
    $error("rx_latency_stamper: SYNC_STAGES out of range");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 64'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                       req_s;
  rx_state_e                  state_q;
  rx_state_e                  state_d;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic [CNT_WIDTH-1:0]       cnt_d;
  logic                       accept;
  logic                       stamp_en;
  logic                       expire;
  logic [AXIS_DATA_WIDTH-1:0] data_st;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .areset(areset),
    .d     (tx_started_req),
    .q     (req_s)
  );

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign stamp_en = (state_q == ST_ARMED) && accept;
  // A beat in the last ARMED cycle beats the timeout.
  assign expire   = (state_q == ST_ARMED) && !accept &&
                    (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_s) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stamp_en || expire)
          state_d = ST_DONE;
        else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + CNT_WIDTH'(1);
        else
          cnt_d = cnt_q;
      end
      ST_DONE: begin
        if (!req_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tx_started_ack <= 1'b0;
      latency_out    <= '0;
      latency_valid  <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_started_ack <= (state_d == ST_DONE);
      latency_valid  <= stamp_en;
      timeout        <= expire;
      if (stamp_en)
        latency_out <= cnt_q;
      else if (expire)
        latency_out <= '1;
    end
  end

  always_comb begin
    data_st = s_axis_tdata;
    if (stamp_en)
      data_st[STAMP_LSB +: CNT_WIDTH] = cnt_q;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      m_axis_tvalid <= 1'b0;
    else if (accept)
      m_axis_tvalid <= 1'b1;
    else if (m_axis_tready)
      m_axis_tvalid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      m_axis_tdata <= data_st;
      m_axis_tkeep <= s_axis_tkeep;
      m_axis_tlast <= s_axis_tlast;
    end
  end

endmodule

// File: tb/tb_rx_latency_stamper.sv
// Directed and randomised checks for rx_latency_stamper.
// 64-bit stream, 16-bit stamp at bit 0, 16-cycle timeout.
module tb_rx_latency_stamper;

  logic        clk;
  logic        areset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        tx_started_req;
  logic        tx_started_ack;
  logic [15:0] latency_out;
  logic        latency_valid;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  rx_latency_stamper #(
    .AXIS_DATA_WIDTH(64),
    .AXIS_KEEP_WIDTH(8),
    .CNT_WIDTH      (16),
    .STAMP_LSB      (0),
    .TIMEOUT_CYCLES (64'd16),
    .SYNC_STAGES    (2)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tx_started_req(tx_started_req),
    .tx_started_ack(tx_started_ack),
    .latency_out   (latency_out),
    .latency_valid (latency_valid),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(input string name);
    bit ok;
    ok = 0;
    tx_started_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (tx_started_ack === 1'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_ack_drop ack=%b want 0 within 4", name, tx_started_ack);
    end
    repeat (2) tick;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    tx_started_req = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = 8'hFF;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mvalid got=%b want=0", m_axis_tvalid);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_sready got=%b want=1", s_axis_tready);
    end
    checks++;
    if ({tx_started_ack, latency_valid, timeout} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b want=000", {tx_started_ack, latency_valid, timeout});
    end
    checks++;
    if (latency_out !== 16'h0) begin
      failures++;
      $display("FAIL rst_lat got=%h want=0000", latency_out);
    end
    areset = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_latency;
    tx_started_req = 1'b1;
    repeat (12) tick;
    checks++;
    if (latency_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_early got=%b want=0", latency_valid);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h1122_3344_5566_7788;
    tick;
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1122_3344_5566_0009) begin
      failures++;
      $display("FAIL lat_stamp got=%b/%h want=1/1122334455660009", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
    if (latency_valid !== 1'b1 || latency_out !== 16'd9) begin
      failures++;
      $display("FAIL lat_value got=%b/%0d want=1/9", latency_valid, latency_out);
    end
    tick;
    checks++;
    if (latency_valid !== 1'b0 || tx_started_ack !== 1'b1) begin
      failures++;
      $display("FAIL lat_pulse_ack got=%b/%b want=0/1", latency_valid, tx_started_ack);
    end
    release_req("lat");
  endtask

  task automatic test_timeout;
    tx_started_req = 1'b1;
    repeat (18) tick;
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_early got=%b want=0", timeout);
    end
    tick;
    checks++;
    if (timeout !== 1'b1 || latency_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse got=%b/%b want=1/0", timeout, latency_valid);
    end
    checks++;
    if (latency_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL to_lat got=%h want=ffff", latency_out);
    end
    tick;
    checks++;
    if (timeout !== 1'b0 || tx_started_ack !== 1'b1) begin
      failures++;
      $display("FAIL to_after got=%b/%b want=0/1", timeout, tx_started_ack);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'hCAFE_F00D_0000_0055;
    tick;
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hCAFE_F00D_0000_0055) begin
      failures++;
      $display("FAIL to_unstamped got=%b/%h want=1/cafef00d00000055", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
    if (latency_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_no_lat got=%b want=0", latency_valid);
    end
    release_req("to");
  endtask

  task automatic test_timeout_race;
    tx_started_req = 1'b1;
    repeat (18) tick;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h0123_4567_89AB_FFFF;
    tick;
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tdata !== 64'h0123_4567_89AB_000F) begin
      failures++;
      $display("FAIL race_stamp got=%h want=0123456789ab000f", m_axis_tdata);
    end
    checks++;
    if (latency_valid !== 1'b1 || timeout !== 1'b0 || latency_out !== 16'd15) begin
      failures++;
      $display("FAIL race_flags got=%b/%b/%0d want=1/0/15", latency_valid, timeout, latency_out);
    end
    tick;
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL race_late_to got=%b want=0", timeout);
    end
    release_req("race");
  endtask

  task automatic test_reset_mid;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h0000_0000_AAAA_5555;
    tick;
    s_axis_tdata = 64'h0000_0000_BBBB_6666;
    tx_started_req = 1'b1;
    repeat (8) tick;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0000_0000_AAAA_5555 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold got=%b/%h/%b want=1/00000000aaaa5555/0", m_axis_tvalid, m_axis_tdata, s_axis_tready);
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_stream got=%b/%b want=0/1", m_axis_tvalid, s_axis_tready);
    end
    checks++;
    if ({tx_started_ack, latency_valid, timeout} !== 3'b000 || latency_out !== 16'h0) begin
      failures++;
      $display("FAIL mid_rst_out got=%b/%h want=000/0000", {tx_started_ack, latency_valid, timeout}, latency_out);
    end
    tx_started_req = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) tick;
    areset = 1'b0;
    tick;
    checks++;
    if ({m_axis_tvalid, tx_started_ack, latency_valid, timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_post got=%b want=0000", {m_axis_tvalid, tx_started_ack, latency_valid, timeout});
    end
    tx_started_req = 1'b1;
    repeat (5) tick;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h7777_8888_9999_AAAA;
    tick;
    s_axis_tvalid = 1'b0;
    checks++;
    if (latency_out !== 16'd2 || m_axis_tdata !== 64'h7777_8888_9999_0002) begin
      failures++;
      $display("FAIL mid_remeasure got=%0d/%h want=2/7777888899990002", latency_out, m_axis_tdata);
    end
    tick;
    release_req("mid");
  endtask

  task automatic test_idle_edge;
    tx_started_req = 1'b1;
    repeat (2) tick;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'hDEAD_BEEF_0BAD_F00D;
    tick;
    checks++;
    if (m_axis_tdata !== 64'hDEAD_BEEF_0BAD_F00D || latency_valid !== 1'b0) begin
      failures++;
      $display("FAIL edge_unstamped got=%h/%b want=deadbeef0badf00d/0", m_axis_tdata, latency_valid);
    end
    s_axis_tdata = 64'hFEDC_BA98_7654_3210;
    tick;
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tdata !== 64'hFEDC_BA98_7654_0000) begin
      failures++;
      $display("FAIL edge_stamp0 got=%h want=fedcba9876540000", m_axis_tdata);
    end
    checks++;
    if (latency_valid !== 1'b1 || latency_out !== 16'd0) begin
      failures++;
      $display("FAIL edge_lat got=%b/%0d want=1/0", latency_valid, latency_out);
    end
    tick;
    release_req("edge");
  endtask

  task automatic test_random;
    logic [72:0] exp_q[$];
    logic [15:0] lat_q[$];
    logic [72:0] e;
    logic [15:0] l;
    logic        acc;
    logic        mv;
    int sent = 0;
    int rcvd = 0;
    int nreq = 0;
    int nstamp = 0;
    int nto = 0;
    int phase = 0;
    int gap = 0;
    int cyc = 0;
    s_axis_tvalid = 1'b0;
    while ((rcvd < 1000 || nreq < 20) && cyc < 40000) begin
      cyc++;
      if (latency_valid === 1'b1) lat_q.push_back(latency_out);
      if (timeout === 1'b1) nto++;
      case (phase)
        0: if (gap == 0) begin tx_started_req = 1'b1; phase = 1; end
           else gap--;
        1: if (tx_started_ack === 1'b1) begin tx_started_req = 1'b0; phase = 2; end
        2: if (tx_started_ack === 1'b0) begin
             nreq++;
             phase = (nreq < 20) ? 0 : 3;
             gap = $urandom_range(0, 40);
           end
        default: ;
      endcase
      m_axis_tready = 1'($urandom_range(0, 1));
      if (!s_axis_tvalid && sent < 1000) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata = {16'hA5C3, 32'(sent), 16'hBEEF};
        s_axis_tkeep = 8'($urandom_range(0, 255));
        s_axis_tlast = 1'($urandom_range(0, 1));
      end
      mv = m_axis_tvalid;
      acc = s_axis_tvalid && (!mv || m_axis_tready);
      if (mv && m_axis_tready) begin
        rcvd++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got=%h want=no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata[63:16]} !== e[72:16]) begin
            failures++;
            $display("FAIL rnd_beat got=%b/%h/%h want=%b/%h/%h", m_axis_tlast, m_axis_tkeep, m_axis_tdata, e[72], e[71:64], e[63:0]);
          end
          if (m_axis_tdata[15:0] !== 16'hBEEF) begin
            nstamp++;
            checks++;
            l = (lat_q.size() > 0) ? lat_q.pop_front() : 16'hFFFF;
            if (m_axis_tdata[15:0] !== l || m_axis_tdata[15:0] > 16'd15) begin
              failures++;
              $display("FAIL rnd_stamp got=%h want=%h (<16)", m_axis_tdata[15:0], l);
            end
          end
        end
      end
      if (acc) begin
        exp_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
        sent++;
      end
      #1;
      checks++;
      if (s_axis_tready !== (!mv || m_axis_tready)) begin
        failures++;
        $display("FAIL rnd_sready got=%b want=%b", s_axis_tready, !mv || m_axis_tready);
      end
      tick;
      if (acc) s_axis_tvalid = 1'b0;
    end
    checks++;
    if (cyc >= 40000) begin
      failures++;
      $display("FAIL rnd_timeout got=%0d beats %0d reqs want=1000/20", rcvd, nreq);
    end
    checks++;
    if (rcvd != 1000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_count got=%0d left=%0d want=1000/0", rcvd, exp_q.size());
    end
    checks++;
    if (nstamp + nto != 20 || lat_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_reqs got=%0d+%0d lat_left=%0d want=20/0", nstamp, nto, lat_q.size());
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_timeout;
    test_timeout_race;
    test_reset_mid;
    test_idle_edge;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
